uart_ip: RTL and testbench

- Memory-mapped 8N1 UART peripheral on the SoC local bus, alongside the GPIO unit.
- Fed by the device-select decode (UART region, upper address nibble stripped) and returns read data to the processor read mux.
- TX path: bus writes push bytes into a small FIFO, which a transmit FSM serialises onto uart_tx.
- RX path: optional receiver with a one-byte holding register.

---
 rtl/uart_ip.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_uart_ip.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ip.sv
// uart_ip -- memory-mapped 8N1 UART peripheral for the SoC local bus.
//
// TX: bus writes to DATA push bytes into a FIFO_DEPTH-entry FIFO; a transmit
// FSM pops them and serialises start/8 data (LSB first)/stop onto uart_tx.
// RX (only when UART_RX_EN is defined): 2-flop synchronised receiver with a
// one-byte holding register and overrun / framing-error flags.
//
// Register map (byte offset, only [3:0] decoded):
//   0x0 DATA     W: push wdata[7:0] (wstrb[0]); R: {24'h0, rx_byte}, clears rx_valid
//   0x4 STATUS   [0] tx_full [1] tx_empty [2] tx_busy [3] rx_valid
//                [4] rx_overrun [5] rx_frame_err [6] tx_overflow (W1C on [6:4])
//   0x8 BAUD_DIV [15:0] bit period - 1, byte-strobed by wstrb[1:0]
//
// Ports:
//   clk, reset_n        system clock, asynchronous active-low reset
//   waddr/wdata/wen/wstrb, wready   write channel (zero wait states)
//   raddr/ren, rdata/rvalid         read channel (one-cycle registered)
//   uart_tx             serial out, idle high
//   uart_rx             serial in (ignored unless UART_RX_EN is defined)
module uart_ip #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DEFAULT_DIV = 433
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] waddr,
  input  logic [31:0] wdata,
  input  logic        wen,
  input  logic [3:0]  wstrb,
  output logic        wready,
  input  logic [31:0] raddr,
  input  logic        ren,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        uart_tx,
  input  logic        uart_rx
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // Bus decode
  logic unused_bits;
  assign unused_bits = ^{waddr[31:4], raddr[31:4], wdata[31:16], wstrb[3:2]};

  logic wr_data, wr_stat, wr_baud;
  assign wready  = wen;
  assign wr_data = wen && (waddr[3:0] == 4'h0) && wstrb[0];
  assign wr_stat = wen && (waddr[3:0] == 4'h4) && wstrb[0];
  assign wr_baud = wen && (waddr[3:0] == 4'h8);

  // TX FIFO
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic full, empty, push, tx_pop;

  assign full  = (count == (PW+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = wr_data && !full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, tx_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Control registers
  logic [15:0] baud_div;
  logic        tx_overflow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_div    <= 16'(DEFAULT_DIV);
      tx_overflow <= 1'b0;
    end else begin
      if (wr_baud && wstrb[0]) baud_div[7:0]  <= wdata[7:0];
      if (wr_baud && wstrb[1]) baud_div[15:8] <= wdata[15:8];
      if (wr_data && full)
        tx_overflow <= 1'b1;
      else if (wr_stat && wdata[6])
        tx_overflow <= 1'b0;
    end
  end

  // TX FSM
  state_t      tx_state, tx_next;
  logic [15:0] tx_cnt, tx_div;
  logic [7:0]  tx_sh;
  logic [2:0]  tx_bit;
  logic        tx_bit_end, tx_line, tx_q, tx_busy;

  assign tx_bit_end = (tx_cnt == tx_div);
  assign tx_busy    = (tx_state != S_IDLE);

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      S_IDLE: begin
        if (!empty) begin
          tx_pop  = 1'b1;
          tx_next = S_START;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) tx_next = S_DATA;
      end
      S_DATA: begin
        tx_line = tx_sh[0];
        if (tx_bit_end && (tx_bit == 3'd7)) tx_next = S_STOP;
      end
      S_STOP: begin
        if (tx_bit_end) tx_next = S_IDLE;
      end
      default: tx_next = S_IDLE;
    endcase
  end

  // uart_tx is registered from the current state, so the line lags the
  // state by one cycle; the async reset forces it high immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_sh    <= '0;
      tx_bit   <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_next;
      tx_q     <= tx_line;
      if (tx_pop) begin
        tx_div <= baud_div;
        tx_sh  <= fifo_mem[rd_ptr];
        tx_cnt <= '0;
        tx_bit <= '0;
      end else if (tx_state != S_IDLE) begin
        if (tx_bit_end) begin
          tx_cnt <= '0;
          if (tx_state == S_DATA) begin
            tx_sh  <= {1'b0, tx_sh[7:1]};
            tx_bit <= tx_bit + 1'b1;
          end
        end else begin
          tx_cnt <= tx_cnt + 1'b1;
        end
      end
    end
  end

  assign uart_tx = tx_q;

  // RX path
  logic [7:0] rx_byte;
  logic       rx_valid, rx_overrun, rx_frame_err;

`ifdef UART_RX_EN
  state_t      rx_state, rx_next;
  logic        rx_s1, rx_s, rx_d, rx_fall;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0]  rx_sh;
  logic [2:0]  rx_bit;
  logic        rx_mid, rx_sample, rx_load, rx_ferr, rd_data_clr;

  assign rx_fall     = rx_d && !rx_s;
  assign rx_mid      = (rx_cnt == (rx_div >> 1));
  assign rx_sample   = (rx_cnt == rx_div);
  assign rd_data_clr = ren && (raddr[3:0] == 4'h0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s  <= rx_s1;
      rx_d  <= rx_s;
    end
  end

  always_comb begin
    rx_next = rx_state;
    rx_load = 1'b0;
    rx_ferr = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_mid)  rx_next = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (rx_sample && (rx_bit == 3'd7)) rx_next = S_STOP;
      S_STOP: begin
        if (rx_sample) begin
          rx_next = S_IDLE;
          rx_load = rx_s;
          rx_ferr = !rx_s;
        end
      end
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_div       <= '0;
      rx_sh        <= '0;
      rx_bit       <= '0;
      rx_byte      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state <= rx_next;
      case (rx_state)
        S_IDLE: begin
          if (rx_fall) begin
            rx_cnt <= '0;
            rx_div <= baud_div;
          end
        end
        S_START: begin
          rx_bit <= '0;
          rx_cnt <= rx_mid ? '0 : rx_cnt + 1'b1;
        end
        S_DATA: begin
          if (rx_sample) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_cnt <= rx_sample ? '0 : rx_cnt + 1'b1;
      endcase

      // A byte landing in the same cycle as a DATA read wins over the clear.
      if (rx_load) begin
        rx_byte  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (rd_data_clr) begin
        rx_valid <= 1'b0;
      end
      if (rx_load && rx_valid)
        rx_overrun <= 1'b1;
      else if (wr_stat && wdata[4])
        rx_overrun <= 1'b0;
      if (rx_ferr)
        rx_frame_err <= 1'b1;
      else if (wr_stat && wdata[5])
        rx_frame_err <= 1'b0;
    end
  end
`else
  logic unused_rx;
  assign unused_rx    = ^{uart_rx, wdata[5:4]};
  assign rx_byte      = '0;
  assign rx_valid     = 1'b0;
  assign rx_overrun   = 1'b0;
  assign rx_frame_err = 1'b0;
`endif

  // Read port
  logic [31:0] status, rd_mux;
  assign status = {25'h0, tx_overflow, rx_frame_err, rx_overrun, rx_valid,
                   tx_busy, empty, full};

  always_comb begin
    rd_mux = '0;
    case (raddr[3:0])
      4'h0:    rd_mux = {24'h0, rx_byte};
      4'h4:    rd_mux = status;
      4'h8:    rd_mux = {16'h0, baud_div};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ren;
      if (ren) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_uart_ip.sv
module tb_uart_ip;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] waddr, wdata, raddr, rdata;
  logic        wen, ren, wready, rvalid, uart_tx, uart_rx;
  logic [3:0]  wstrb;
  logic        loopback, rx_drv;

  always #5 clk = ~clk;

  assign uart_rx = loopback ? uart_tx : rx_drv;

  uart_ip #(.FIFO_DEPTH(4), .DEFAULT_DIV(433)) dut (
    .clk(clk), .reset_n(reset_n),
    .waddr(waddr), .wdata(wdata), .wen(wen), .wstrb(wstrb), .wready(wready),
    .raddr(raddr), .ren(ren), .rdata(rdata), .rvalid(rvalid),
    .uart_tx(uart_tx), .uart_rx(uart_rx)
  );

  int checks = 0;
  int errors = 0;
  int bit_cyc = 434;
  logic [8:0]  mon_q[$];   // {stop, byte} as decoded from uart_tx
  logic [7:0]  tx_exp[$];  // bytes expected on uart_tx
  logic [31:0] rd_exp[$];  // expected read data
  logic [31:0] got, exp;
  logic [8:0]  m;
  logic [7:0]  e;

  // uart_tx frame decoder; frames overlapping a reset are discarded
  initial begin
    logic [7:0] b;
    logic       abort, stop;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && uart_tx === 1'b0) begin
        abort = 1'b0;
        b = '0;
        repeat (bit_cyc / 2) @(negedge clk);
        if (uart_tx !== 1'b0 || reset_n !== 1'b1) abort = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (bit_cyc) @(negedge clk);
          b[i] = uart_tx;
          if (reset_n !== 1'b1) abort = 1'b1;
        end
        repeat (bit_cyc) @(negedge clk);
        stop = uart_tx;
        if (reset_n !== 1'b1) abort = 1'b1;
        if (!abort) mon_q.push_back({stop, b});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    waddr = {28'h0, a};
    wdata = d;
    wstrb = s;
    wen   = 1'b1;
    tick();
    wen   = 1'b0;
    wstrb = 4'h0;
  endtask

  // Returns X when rvalid never shows up, so the caller's comparison fails.
  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    raddr = {28'h0, a};
    ren   = 1'b1;
    tick();
    ren   = 1'b0;
    d     = 'x;
    for (int i = 0; i < 4; i++) begin
      if (rvalid === 1'b1) begin
        d = rdata;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (mon_q.size() >= n) break;
      tick();
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_drv = bits[i];
      repeat (bit_cyc) tick();
    end
    rx_drv = 1'b1;
    repeat (2 * bit_cyc) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++; if (rvalid !== 1'b0 || wready !== 1'b0) begin errors++; $display("FAIL reset_hs: got rvalid=%b wready=%b want 0/0", rvalid, wready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    reset_n = 1'b1;
    tick();
    rd_exp.push_back(32'h2);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_status: got %h want %h", got, exp); end
    rd_exp.push_back(32'd433);
    bus_read(4'h8, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_baud: got %h want %h", got, exp); end
    repeat (3) tick();
    checks++; if (rdata !== exp) begin errors++; $display("FAIL rdata_hold: got %h want %h", rdata, exp); end
    rd_exp.push_back(32'h0);
    bus_read(4'hC, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL unmapped_read: got %h want %h", got, exp); end
  endtask

  task automatic test_tx_single();
    logic [7:0] b;
    logic       exp_tx, exp_busy;
    int         idx;
    bus_write(4'h8, 32'h3, 4'h3);
    bit_cyc = 4;
    b = 8'h55;
    tx_exp.push_back(b);
    waddr = 32'h0; wdata = {24'h0, b}; wstrb = 4'h1; wen = 1'b1;
    raddr = 32'h4; ren = 1'b1;
    #1;
    checks++; if (wready !== 1'b1) begin errors++; $display("FAIL wready_comb: got %b want 1", wready); end
    @(posedge clk); #1;
    wen = 1'b0; wstrb = 4'h0;
    // k-th sample is taken after the k-th edge following the push; STATUS is
    // read every cycle, so rdata[2] reflects tx_busy one cycle earlier.
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k < 3 || k > 42) exp_tx = 1'b1;
      else begin
        idx = (k - 3) / 4;
        if (idx == 0) exp_tx = 1'b0;
        else if (idx == 9) exp_tx = 1'b1;
        else exp_tx = b[idx-1];
      end
      exp_busy = (k >= 3 && k <= 42);
      checks++; if (uart_tx !== exp_tx) begin errors++; $display("FAIL tx_wave[%0d]: got %b want %b", k, uart_tx, exp_tx); end
      checks++; if (rdata[2] !== exp_busy) begin errors++; $display("FAIL tx_busy[%0d]: got %b want %b", k, rdata[2], exp_busy); end
    end
    ren = 1'b0;
    tick();
    checks++; if (wready !== 1'b0) begin errors++; $display("FAIL wready_idle: got %b want 0", wready); end
    wait_frames(1, 40);
    e = tx_exp.pop_front();
    if (mon_q.size() > 0) m = mon_q.pop_front(); else m = 9'h0;
    checks++; if (m !== {1'b1, e}) begin errors++; $display("FAIL tx_frame: got %h want %h", m, {1'b1, e}); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      // first byte pops at once, four fill the FIFO, the sixth is dropped
      if (i < 5) tx_exp.push_back(8'((i + 1) * 8'h11));
      bus_write(4'h0, 32'((i + 1) * 8'h11), 4'h1);
    end
    rd_exp.push_back(32'h45);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_status: got %h want %h", got, exp); end
    bus_write(4'h4, 32'h40, 4'h1);
    rd_exp.push_back(32'h05);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL ovf_clear: got %h want %h", got, exp); end
    wait_frames(5, 400);
    for (int i = 0; i < 5; i++) begin
      e = tx_exp.pop_front();
      if (mon_q.size() > 0) m = mon_q.pop_front(); else m = 9'h0;
      checks++; if (m !== {1'b1, e}) begin errors++; $display("FAIL b2b_frame[%0d]: got %h want %h", i, m, {1'b1, e}); end
    end
    repeat (100) tick();
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL b2b_extra_frames: got %0d want 0", mon_q.size()); end
    rd_exp.push_back(32'h02);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_idle_status: got %h want %h", got, exp); end
  endtask

  task automatic test_rx();
    loopback = 1'b1;
    tx_exp.push_back(8'hA5);
    bus_write(4'h0, 32'hA5, 4'h1);
    wait_frames(1, 100);
    e = tx_exp.pop_front();
    if (mon_q.size() > 0) m = mon_q.pop_front(); else m = 9'h0;
    checks++; if (m !== {1'b1, e}) begin errors++; $display("FAIL loop_tx_frame: got %h want %h", m, {1'b1, e}); end
    repeat (10) tick();
    loopback = 1'b0;
`ifdef UART_RX_EN
    rd_exp.push_back(32'h0A);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rx_status: got %h want %h", got, exp); end
    rd_exp.push_back(32'hA5);
    bus_read(4'h0, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rx_data: got %h want %h", got, exp); end
    rd_exp.push_back(32'h02);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rx_valid_clear: got %h want %h", got, exp); end
    // one-cycle glitch is a false start
    bus_write(4'h8, 32'h7, 4'h3);
    bit_cyc = 8;
    rx_drv = 1'b0; tick(); rx_drv = 1'b1;
    repeat (40) tick();
    rd_exp.push_back(32'h02);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rx_glitch: got %h want %h", got, exp); end
    rx_send(8'h3C, 1'b0);
    rd_exp.push_back(32'h22);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rx_frame_err: got %h want %h", got, exp); end
    bus_write(4'h4, 32'h20, 4'h1);
    rx_send(8'h3C, 1'b1);
    rx_send(8'hC3, 1'b1);
    rd_exp.push_back(32'h1A);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rx_overrun: got %h want %h", got, exp); end
    rd_exp.push_back(32'hC3);
    bus_read(4'h0, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rx_overwrite: got %h want %h", got, exp); end
    bus_write(4'h4, 32'h10, 4'h1);
    rd_exp.push_back(32'h02);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL rx_w1c: got %h want %h", got, exp); end
`else
    rd_exp.push_back(32'h0);
    bus_read(4'h0, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL norx_data: got %h want %h", got, exp); end
    rd_exp.push_back(32'h02);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL norx_status: got %h want %h", got, exp); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    bus_write(4'h8, 32'h3, 4'h3);
    bit_cyc = 4;
    bus_write(4'h0, 32'h0F, 4'h1);
    bus_write(4'h0, 32'hF0, 4'h1);
    repeat (12) tick();
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_async_tx: got %b want 1", uart_tx); end
    repeat (6) tick();
    reset_n = 1'b1;
    tick();
    rd_exp.push_back(32'h02);
    bus_read(4'h4, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_mid_status: got %h want %h", got, exp); end
    rd_exp.push_back(32'd433);
    bus_read(4'h8, got); exp = rd_exp.pop_front();
    checks++; if (got !== exp) begin errors++; $display("FAIL reset_mid_baud: got %h want %h", got, exp); end
    repeat (60) tick();
    checks++; if (mon_q.size() != 0 || uart_tx !== 1'b1) begin errors++; $display("FAIL reset_mid_quiet: got frames=%0d tx=%b want 0/1", mon_q.size(), uart_tx); end
  endtask

  initial begin
    reset_n = 1'b0;
    waddr = '0; wdata = '0; wstrb = '0; wen = 1'b0;
    raddr = '0; ren = 1'b0;
    loopback = 1'b0; rx_drv = 1'b1;
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
